// File: rtl/prime_logger.sv
// Prime logger: captures primes reported by an upstream checker into a
// first-word-fall-through FIFO and keeps running statistics about them
// (count, most recent prime, largest gap, overflow/order flags).
//
// Output handshake: out_data is valid while out_valid is high; an entry is
// consumed on any rising edge where out_valid and out_ready are both 1.
// There is no backpressure on the input side; a prime that finds the FIFO
// full (and no same-edge pop) is dropped and flagged.
module prime_logger #(
    parameter int DEPTH = 16,
    parameter int W     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_number,
    input  logic                     in_prime,
    input  logic                     clr,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [W-1:0]             prime_count,
    output logic [W-1:0]             last_prime,
    output logic [W-1:0]             max_gap,
    output logic                     overflow,
    output logic                     order_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [W-1:0]  r_count;
    logic [W-1:0]  r_last_prime;
    logic [W-1:0]  r_max_gap;
    logic          r_overflow;
    logic          r_order_err;
    logic          r_have_prime;   // a prime has been captured since reset/clr
    logic          r_have_num;     // a valid number has been seen since reset/clr
    logic [W-1:0]  r_prev_num;     // last valid number, for order checking

    logic          w_capture;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic          w_order_bad;
    logic [W-1:0]  w_gap;
    logic          w_gap_update;

    // Decode this edge's events; a clear suppresses every other action.
    always_comb begin
        w_capture    = in_valid & in_prime & ~clr;
        w_pop        = (r_level != '0) & out_ready & ~clr;
        w_full       = (r_level == LEVEL_FULL);
        w_push       = w_capture & (~w_full | w_pop);
        w_drop       = w_capture & w_full & ~w_pop;
        w_order_bad  = in_valid & ~clr & r_have_num & (in_number <= r_prev_num);
        w_gap        = in_number - r_last_prime;
        w_gap_update = w_capture & r_have_prime & ~w_order_bad & (w_gap > r_max_gap);
    end

    // FIFO storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_number;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
        end
    end

    // Statistics, sticky flags and ordering history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count      <= '0;
            r_last_prime <= '0;
            r_max_gap    <= '0;
            r_overflow   <= 1'b0;
            r_order_err  <= 1'b0;
            r_have_prime <= 1'b0;
            r_have_num   <= 1'b0;
            r_prev_num   <= '0;
        end else if (clr) begin
            r_count      <= '0;
            r_last_prime <= '0;
            r_max_gap    <= '0;
            r_overflow   <= 1'b0;
            r_order_err  <= 1'b0;
            r_have_prime <= 1'b0;
            r_have_num   <= 1'b0;
            r_prev_num   <= '0;
        end else begin
            if (in_valid) begin
                r_prev_num <= in_number;
                r_have_num <= 1'b1;
            end
            if (w_order_bad) r_order_err <= 1'b1;
            if (w_drop)      r_overflow  <= 1'b1;
            if (w_capture) begin
                if (r_count != '1) r_count <= r_count + 1'b1;
                r_last_prime <= in_number;
                r_have_prime <= 1'b1;
            end
            if (w_gap_update) r_max_gap <= w_gap;
        end
    end

    // Outputs come straight from registers; the head is masked when empty so
    // out_data reads 0 during and after reset.
    assign out_valid   = (r_level != '0);
    assign out_data    = out_valid ? r_mem[r_rd_ptr] : '0;
    assign level       = r_level;
    assign prime_count = r_count;
    assign last_prime  = r_last_prime;
    assign max_gap     = r_max_gap;
    assign overflow    = r_overflow;
    assign order_err   = r_order_err;

endmodule

// File: tb/tb_prime_logger.sv
// Bench for prime_logger: directed scenarios, a queue-based reference model
// updated on each rising edge, a per-cycle compare on the falling edge, and
// literal expectations that pin the model.
module tb_prime_logger;

    localparam int DEPTH = 16;
    localparam int W     = 11;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_number;
    logic          in_prime;
    logic          clr;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [LW-1:0] level;
    logic [W-1:0]  prime_count;
    logic [W-1:0]  last_prime;
    logic [W-1:0]  max_gap;
    logic          overflow;
    logic          order_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int m_count      = 0;
    int m_last       = 0;
    int m_max        = 0;
    int m_have_prime = 0;
    int m_have_num   = 0;
    int m_prev       = 0;
    int m_ovf        = 0;
    int m_oerr       = 0;

    int primes[17] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59};

    prime_logger #(.DEPTH(DEPTH), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_number   (in_number),
        .in_prime    (in_prime),
        .clr         (clr),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .level       (level),
        .prime_count (prime_count),
        .last_prime  (last_prime),
        .max_gap     (max_gap),
        .overflow    (overflow),
        .order_err   (order_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_count = 0; m_last = 0; m_max = 0; m_have_prime = 0;
        m_have_num = 0; m_prev = 0; m_ovf = 0; m_oerr = 0;
    endtask

    // Reference model: evaluated on each rising edge (or async reset)
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst || clr) begin
                model_clear();
            end else begin
                bit popped;
                bit bad;
                popped = (exp_q.size() > 0) && out_ready;
                if (popped) got_q.push_back(exp_q.pop_front());
                bad = in_valid && m_have_num && (int'(in_number) <= m_prev);
                if (in_valid) begin
                    if (bad) m_oerr = 1;
                    m_prev = in_number;
                    m_have_num = 1;
                end
                if (in_valid && in_prime) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(in_number);
                    else m_ovf = 1;
                    if (m_count < (1 << W) - 1) m_count++;
                    if (m_have_prime && !bad && (int'(in_number) - m_last > m_max))
                        m_max = int'(in_number) - m_last;
                    m_last = in_number;
                    m_have_prime = 1;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, exp_q.size() > 0);
            chk("level", level, exp_q.size());
            chk("out_data", out_data, (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
            chk("prime_count", prime_count, m_count);
            chk("last_prime", last_prime, m_last);
            chk("max_gap", max_gap, m_max);
            chk("overflow", overflow, m_ovf);
            chk("order_err", order_err, m_oerr);
        end
    end

    // Driver: apply one cycle of inputs, return at the following falling edge
    task automatic drive(input bit v, input int n, input bit p, input bit c, input bit r);
        in_valid  = v;
        in_number = W'(n);
        in_prime  = p;
        clr       = c;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles, input bit r);
        for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0, r);
    endtask

    task automatic chk_got(input string name, input int count);
        chk({name, "_len"}, got_q.size(), count);
        for (int i = 0; i < count && i < got_q.size(); i++)
            chk(name, got_q[i], primes[i]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_prime_count"}, prime_count, 0);
        chk({tag, "_last_prime"}, last_prime, 0);
        chk({tag, "_max_gap"}, max_gap, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_order_err"}, order_err, 0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_number = '0; in_prime = 1'b0;
        clr = 1'b0; out_ready = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Stream 2..20 with a ready consumer
        got_q.delete();
        for (int n = 2; n <= 20; n++) drive(1, n, is_prime(n), 0, 1);
        idle(3, 1);
        chk("s1_count", prime_count, 8);
        chk("s1_last", last_prime, 19);
        chk("s1_max_gap", max_gap, 4);
        chk_got("s1_seq", 8);

        // Fill past capacity with a stalled consumer, then drain
        drive(0, 0, 0, 1, 0);
        got_q.delete();
        for (int n = 2; n <= 59; n++) begin
            drive(1, n, is_prime(n), 0, 0);
            if (n == 53) chk("s2_ovf_before", overflow, 0);
        end
        chk("s2_level", level, 16);
        chk("s2_ovf", overflow, 1);
        chk("s2_count", prime_count, 17);
        idle(18, 1);
        chk_got("s2_seq", 16);

        // Full FIFO with simultaneous capture and pop
        drive(0, 0, 0, 1, 0);
        got_q.delete();
        for (int i = 0; i < 16; i++) drive(1, primes[i], 1, 0, 0);
        chk("s3_level_full", level, 16);
        drive(1, 59, 1, 0, 1);
        chk("s3_level", level, 16);
        chk("s3_ovf", overflow, 0);
        chk("s3_head", out_data, 3);
        idle(1, 0);
        idle(18, 1);
        chk_got("s3_seq", 17);

        // Non-increasing input numbers
        drive(0, 0, 0, 1, 1);
        drive(1, 7, 1, 0, 1);
        drive(1, 5, 1, 0, 1);
        chk("s4_order_err", order_err, 1);
        chk("s4_max_gap", max_gap, 0);
        chk("s4_count", prime_count, 2);
        chk("s4_last", last_prime, 5);
        drive(1, 11, 1, 0, 1);
        chk("s4_max_gap_after", max_gap, 6);
        idle(2, 1);

        // Asynchronous reset mid-operation, then clear with concurrent capture
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, primes[i], 1, 0, 0);
        chk("s5_level", level, 5);
        #2 rst = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        drive(1, 13, 1, 0, 0);
        drive(1, 17, 1, 0, 0);
        drive(1, 19, 1, 0, 0);
        chk("s5_level_after", level, 3);
        chk("s5_order_after", order_err, 0);
        chk("s5_max_gap_after", max_gap, 4);
        drive(1, 23, 1, 1, 0);
        chk_all_zero("clr");
        idle(2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prime_logger.md
PRIME_LOGGER -- requirements
Module: prime_logger

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the FIFO entry count; legal values are powers of two from 4 to 64.
REQ-002 Parameter W, default 11, SHALL set the data width of numbers, counts and gaps.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low (0 = reset).
REQ-005 in_valid  input  1  SHALL qualify in_number/in_prime for one checked number per cycle from the upstream prime checker.
REQ-006 in_number  input  W  SHALL carry the number just checked.
REQ-007 in_prime  input  1  SHALL be 1 when in_number is prime.
REQ-008 clr  input  1  SHALL be a synchronous clear of the FIFO, statistics and flags.
REQ-009 out_ready  input  1  SHALL be the consumer's ready signal.
REQ-010 out_valid  output  1  SHALL be high when the FIFO is non-empty.
REQ-011 out_data  output  W  SHALL carry the FIFO head prime, valid only while out_valid is high.
REQ-012 level  output  clog2(DEPTH)+1  SHALL report the current FIFO occupancy.
REQ-013 prime_count  output  W  SHALL report the total number of primes seen since reset/clr.
REQ-014 last_prime  output  W  SHALL report the most recent prime seen.
REQ-015 max_gap  output  W  SHALL report the largest difference between consecutive primes seen.
REQ-016 overflow  output  1  SHALL be a sticky flag set when a prime was dropped because the FIFO was full.
REQ-017 order_err  output  1  SHALL be a sticky flag set when the input numbers were not strictly increasing.

Function
REQ-018 A capture SHALL occur on a clock edge where in_valid=1 and in_prime=1; in_number is ignored when in_valid=0.
REQ-019 A pop SHALL occur on a clock edge where out_valid=1 and out_ready=1; out_data SHALL then advance to the next entry.
REQ-020 FIFO: first-word-fall-through; a captured prime SHALL appear on out_data with out_valid=1 one cycle after capture; no same-cycle bypass when empty.
REQ-021 Capture when level<DEPTH SHALL push; capture and pop on the same edge SHALL both take effect, including when full, with level unchanged.
REQ-022 Capture when level=DEPTH without a same-edge pop SHALL drop the prime, set overflow, and still update the statistics.
REQ-023 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-024 Every capture SHALL increment prime_count, saturating at 2^W-1, and SHALL load last_prime with in_number.
REQ-025 Gap = in_number - last_prime, computed on a capture only when a prior prime exists; max_gap SHALL load the gap when it exceeds max_gap.
REQ-026 The first capture after reset/clr SHALL NOT update max_gap.
REQ-027 Any in_valid cycle with in_number <= the previous valid in_number (not the first since reset/clr) SHALL set order_err.
  - On such a cycle, if it is also a capture, no gap is computed; the push and the count update still occur.
REQ-028 clr=1 SHALL, on that edge, empty the FIFO and zero the statistics and flags; a capture on the same edge SHALL be ignored.
REQ-029 All outputs SHALL be registered or derived only from registers (no combinational path from inputs).

Reset
REQ-030 While rst=0, all outputs SHALL immediately be 0: out_valid, out_data, level, prime_count, last_prime, max_gap, overflow, order_err.
REQ-031 The pointers and the "prior prime/prior number seen" state SHALL be cleared by reset.
REQ-032 Reset asserted mid-operation SHALL discard the FIFO contents; operation resumes on the first edge after rst returns to 1.

Verification
REQ-033 Stream 2..20, one per cycle, in_prime correct, out_ready=1 -> out_data sequence 2,3,5,7,11,13,17,19, prime_count=8, last_prime=19, max_gap=4.
REQ-034 out_ready=0, feed primes 2..59 (17 primes), DEPTH=16 -> level=16, overflow=1 after the 17th, prime_count=17; draining yields 2..53 in order.
REQ-035 Full FIFO, capture plus out_ready=1 on the same edge -> level stays 16, overflow stays 0, new prime enters the tail.
REQ-036 in_number sequence 7,5 (both valid) -> order_err=1; no max_gap change from the 5.
REQ-037 Assert rst=0 asynchronously between edges while level=5 -> all outputs 0 before the next edge; clr=1 with a concurrent capture -> all zero and the capture is ignored.
